fetch_pq: RTL and testbench

Parametrised prefetching instruction-fetch stage, the successor to the single-slot fetch stage. It runs ahead of decode, issuing sequential IFU reads into a DEPTH-entry prefetch queue of {pc, instr, err_bus, err_align}. It presents the queue head to decode. Jump and exception redirects flush the queue and discard any in-flight read.

---
 rtl/fetch_pq_pkg.sv | 27 ++
 rtl/fetch_pq_queue.sv | 63 ++++++
 rtl/fetch_pq.sv | 153 +++++++++++++++
 tb/tb_fetch_pq.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pq_pkg.sv
// Shared CPU constants for the prefetching fetch stage.
// Holds the default address/instruction widths, the NOP encoding, the
// sequential PC step, the bit layout of a prefetch queue entry and the
// redirect source encoding.
package fetch_pq_pkg;

  localparam int unsigned CPU_ADDR_WIDTH  = 32;
  localparam int unsigned CPU_INSTR_WIDTH = 32;
  localparam logic [31:0] CPU_NOP         = 32'h0000_0000;
  localparam int unsigned PC_STEP         = 4;

  // Queue entry layout, LSB first: err_align, err_bus, instr, pc.
  localparam int unsigned ENT_ERR_ALIGN = 0;
  localparam int unsigned ENT_ERR_BUS   = 1;
  localparam int unsigned ENT_INSTR_LSB = 2;

  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned iw);
    return aw + iw + 2;
  endfunction

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_JUMP,
    REDIR_EXCEPT
  } redir_e;

endpackage

// File: rtl/fetch_pq_queue.sv
// fetch_queue: synchronous FIFO holding prefetched {pc, instr, err_bus, err_align}.
// Ports:
//   clk, rst      clock and synchronous active-high reset (pointers/count only)
//   flush         empties the queue; wins over a same-cycle push
//   push, din     write an entry (accepted when not full, or full with a pop)
//   pop           drop the head entry (ignored when empty)
//   head          current head entry, combinational
//   count         number of valid entries (0..DEPTH)
//   full, empty   occupancy flags
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_pq.sv
// fetch_pq: prefetching instruction-fetch stage.
// Runs ahead of decode, issuing one sequential IFU read at a time into a
// DEPTH-entry prefetch queue and presenting the queue head to decode.
// Jump/exception redirects flush the queue and discard any in-flight read.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_jump_valid/i_jump_addr         jump redirect
//   i_except_valid/i_except_haddr    exception redirect (wins over jump)
//   i_exec_stall, i_mem_stall        head not consumed this cycle
//   i_nullify                        head killed (NOP out) but still popped
//   o_fetch_stall                    no valid instruction at the head
//   o_bus_error, o_addr_error        head entry error flags
//   o_addr, o_rd_cmd                 IFU read address and one-cycle strobe
//   i_busy                           IFU cannot accept a command
//   i_rsp_valid, i_instr_dat,
//   i_err_align, i_err_bus           IFU response
//   o_instr, o_pc                    instruction and PC presented to decode
module fetch_pq
  import fetch_pq_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = CPU_ADDR_WIDTH,
  parameter int unsigned             INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter int unsigned             DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP         = INSTR_WIDTH'(CPU_NOP)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_jump_addr,
  input  logic                    i_jump_valid,
  input  logic                    i_except_valid,
  input  logic [ADDR_WIDTH-1:0]   i_except_haddr,
  input  logic                    i_exec_stall,
  input  logic                    i_mem_stall,
  input  logic                    i_nullify,
  output logic                    o_fetch_stall,
  output logic                    o_bus_error,
  output logic                    o_addr_error,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_rd_cmd,
  input  logic                    i_busy,
  input  logic                    i_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]  i_instr_dat,
  input  logic                    i_err_align,
  input  logic                    i_err_bus,
  output logic [INSTR_WIDTH-1:0]  o_instr,
  output logic [ADDR_WIDTH-1:0]   o_pc
);

  localparam int unsigned EW = entry_width(ADDR_WIDTH, INSTR_WIDTH);

  logic [ADDR_WIDTH-1:0] fpc;
  logic                  outstanding;
  logic                  discard;
  logic                  halted;

  redir_e                redir;
  logic [ADDR_WIDTH-1:0] redir_target;
  logic                  redirect;
  logic                  rsp_take;
  logic                  rsp_err;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [EW-1:0]         push_entry;

  logic [EW-1:0]         q_head;
  logic [$clog2(DEPTH):0] q_count;
  logic                  q_full;
  logic                  q_empty;
  logic                  head_valid;

  always_comb begin
    redir        = REDIR_NONE;
    redir_target = '0;
    if (i_except_valid) begin
      redir        = REDIR_EXCEPT;
      redir_target = i_except_haddr;
    end else if (i_jump_valid) begin
      redir        = REDIR_JUMP;
      redir_target = i_jump_addr;
    end
  end

  assign redirect = (redir != REDIR_NONE);

  // Responses only count while a read is in flight; a stray strobe right
  // after reset is ignored.
  assign rsp_take = i_rsp_valid && outstanding;
  assign rsp_err  = i_err_bus || i_err_align;
  assign push     = rsp_take && !discard && !redirect;
  assign pop      = !q_empty && !i_exec_stall && !i_mem_stall;

  // Room check uses occupancy after this cycle's pop; with at most one read
  // in flight this keeps count + outstanding <= DEPTH.
  assign issue = !i_busy && !outstanding && !halted && !redirect && (!q_full || pop);

  assign push_entry = {o_addr, (rsp_err ? NOP : i_instr_dat), i_err_bus, i_err_align};

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      halted      <= 1'b0;
      o_rd_cmd    <= 1'b0;
      o_addr      <= '0;
    end else begin
      o_rd_cmd <= issue;
      if (issue) begin
        o_addr <= fpc;
        fpc    <= fpc + ADDR_WIDTH'(PC_STEP);
      end
      if (redirect) fpc <= redir_target;

      if (issue)         outstanding <= 1'b1;
      else if (rsp_take) outstanding <= 1'b0;

      // A read still in flight across a redirect belongs to the old stream.
      if (redirect)      discard <= outstanding && !rsp_take;
      else if (rsp_take) discard <= 1'b0;

      // An error entry stops prefetch until software redirects.
      if (redirect)             halted <= 1'b0;
      else if (push && rsp_err) halted <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head_valid    = (q_count != '0);
  assign o_fetch_stall = q_empty;
  assign o_instr       = (!head_valid || i_nullify || redirect)
                         ? NOP : q_head[ENT_INSTR_LSB +: INSTR_WIDTH];
  assign o_pc          = head_valid ? q_head[ENT_INSTR_LSB + INSTR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_bus_error   = head_valid && q_head[ENT_ERR_BUS];
  assign o_addr_error  = head_valid && q_head[ENT_ERR_ALIGN];

endmodule

// File: tb/tb_fetch_pq.sv
// Self-checking bench for fetch_pq: an IFU responder, a queue-based
// reference model checked every cycle, and directed scenarios.
module tb_fetch_pq;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_jump_addr;
  logic        i_jump_valid;
  logic        i_except_valid;
  logic [31:0] i_except_haddr;
  logic        i_exec_stall;
  logic        i_mem_stall;
  logic        i_nullify;
  logic        o_fetch_stall;
  logic        o_bus_error;
  logic        o_addr_error;
  logic [31:0] o_addr;
  logic        o_rd_cmd;
  logic        i_busy;
  logic        i_rsp_valid;
  logic [31:0] i_instr_dat;
  logic        i_err_align;
  logic        i_err_bus;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  always #5 clk = ~clk;

  fetch_pq #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .DEPTH       (DEPTH),
    .RESET_PC    (32'h0),
    .NOP         (NOP_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_jump_addr    (i_jump_addr),
    .i_jump_valid   (i_jump_valid),
    .i_except_valid (i_except_valid),
    .i_except_haddr (i_except_haddr),
    .i_exec_stall   (i_exec_stall),
    .i_mem_stall    (i_mem_stall),
    .i_nullify      (i_nullify),
    .o_fetch_stall  (o_fetch_stall),
    .o_bus_error    (o_bus_error),
    .o_addr_error   (o_addr_error),
    .o_addr         (o_addr),
    .o_rd_cmd       (o_rd_cmd),
    .i_busy         (i_busy),
    .i_rsp_valid    (i_rsp_valid),
    .i_instr_dat    (i_instr_dat),
    .i_err_align    (i_err_align),
    .i_err_bus      (i_err_bus),
    .o_instr        (o_instr),
    .o_pc           (o_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched entries plus the fetch PC,
  // the one in-flight request and the discard/halt flags.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        eb;
    logic        ea;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc, m_addr;
  logic        m_rdcmd, m_out, m_discard, m_halted;

  // IFU responder state.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat_fixed;
  int          err_pct;
  logic [31:0] bus_err_addr;

  logic        chk_en;
  logic        obs_rdcmd, obs_stall, obs_be, obs_ae;
  logic [31:0] obs_addr, obs_instr, obs_pc;
  logic [31:0] rd_log[$];
  logic [31:0] pc_log[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] at_or(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic ifu_drive();
    i_rsp_valid = 1'b0;
    i_instr_dat = $urandom;
    i_err_bus   = 1'b0;
    i_err_align = 1'b0;
    if (pend) begin
      pend_wait--;
      if (pend_wait <= 0) begin
        pend        = 1'b0;
        i_rsp_valid = 1'b1;
        i_instr_dat = word_at(pend_addr);
        i_err_bus   = (pend_addr == bus_err_addr) || ($urandom_range(0, 99) < err_pct);
        i_err_align = ($urandom_range(0, 99) < err_pct);
      end
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    logic any;
    any = (mq.size() != 0);
    h   = '0;
    if (any) h = mq[0];
    chk("rd_cmd", o_rd_cmd, m_rdcmd);
    chk("o_addr", o_addr, m_addr);
    chk("fetch_stall", o_fetch_stall, !any);
    chk("o_pc", o_pc, h.pc);
    chk("o_instr", o_instr,
        (!any || i_nullify || i_jump_valid || i_except_valid) ? NOP_W : h.instr);
    chk("bus_err", o_bus_error, h.eb);
    chk("addr_err", o_addr_error, h.ea);
  endtask

  task automatic model_step();
    logic        redir, take, pop, room, issue, err;
    logic [31:0] tgt;
    ent_t        e;
    if (rst) begin
      m_fpc = 32'h0; m_addr = 32'h0; m_rdcmd = 1'b0;
      m_out = 1'b0; m_discard = 1'b0; m_halted = 1'b0;
      mq.delete();
      return;
    end
    redir = i_except_valid || i_jump_valid;
    tgt   = i_except_valid ? i_except_haddr : i_jump_addr;
    take  = i_rsp_valid && m_out;
    pop   = (mq.size() != 0) && !i_exec_stall && !i_mem_stall;
    room  = (mq.size() - (pop ? 1 : 0)) < DEPTH;
    issue = !i_busy && !m_out && !m_halted && !redir && room;
    if (redir) begin
      mq.delete();
      m_halted  = 1'b0;
      m_discard = m_out && !take;
      m_fpc     = tgt;
    end else begin
      if (pop) void'(mq.pop_front());
      if (take && !m_discard) begin
        err     = i_err_bus || i_err_align;
        e.pc    = m_addr;
        e.instr = err ? NOP_W : i_instr_dat;
        e.eb    = i_err_bus;
        e.ea    = i_err_align;
        mq.push_back(e);
        if (err) m_halted = 1'b1;
      end
      if (take) m_discard = 1'b0;
      if (issue) begin
        m_addr = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
    end
    if (take)  m_out = 1'b0;
    if (issue) m_out = 1'b1;
    m_rdcmd = issue;
  endtask

  // One clock cycle: inputs were set after the last rising edge; outputs
  // are sampled on the falling edge.
  task automatic step();
    ifu_drive();
    @(negedge clk);
    obs_rdcmd = o_rd_cmd;  obs_addr  = o_addr;   obs_stall = o_fetch_stall;
    obs_instr = o_instr;   obs_pc    = o_pc;     obs_be    = o_bus_error;
    obs_ae    = o_addr_error;
    if (chk_en) check_outputs();
    if (o_rd_cmd) rd_log.push_back(o_addr);
    if (!o_fetch_stall && !i_exec_stall && !i_mem_stall && !i_jump_valid && !i_except_valid)
      pc_log.push_back(o_pc);
    model_step();
    if (o_rd_cmd && !rst) begin
      pend      = 1'b1;
      pend_addr = o_addr;
      pend_wait = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 3);
    end
    if (rst) pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_log.delete();
    pc_log.delete();
  endtask

  task automatic wait_head();
    for (int k = 0; k < 30; k++) begin
      step();
      if (!obs_stall) break;
    end
  endtask

  int   n0;
  logic found;

  initial begin
    rst = 1'b1; i_jump_addr = '0; i_jump_valid = 1'b0; i_except_valid = 1'b0;
    i_except_haddr = '0; i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_nullify = 1'b0;
    i_busy = 1'b0; i_rsp_valid = 1'b0; i_instr_dat = '0; i_err_align = 1'b0; i_err_bus = 1'b0;
    pend = 1'b0; pend_addr = '0; pend_wait = 0; lat_fixed = 1; err_pct = 0;
    bus_err_addr = 32'hFFFF_FFFF; chk_en = 1'b0;
    @(posedge clk); #1;
    step();
    chk_en = 1'b1;

    // Reset state, then sequential fetch with a 1-cycle IFU.
    do_reset();
    step();
    chk("reset_stall", obs_stall, 1'b1);
    chk("reset_rdcmd", obs_rdcmd, 1'b0);
    chk("reset_instr", obs_instr, NOP_W);
    chk("reset_pc", obs_pc, 32'h0);
    repeat (30) step();
    chk("seq_rd0", at_or(rd_log, 0), 32'h0);
    chk("seq_rd1", at_or(rd_log, 1), 32'h4);
    chk("seq_rd2", at_or(rd_log, 2), 32'h8);
    chk("seq_pc0", at_or(pc_log, 0), 32'h0);
    chk("seq_pc1", at_or(pc_log, 1), 32'h4);
    chk("seq_pc2", at_or(pc_log, 2), 32'h8);

    // Execute stall: queue fills to DEPTH and no fifth read until a pop.
    do_reset();
    i_exec_stall = 1'b1;
    repeat (20) step();
    chk("stall_nrd", rd_log.size(), DEPTH);
    chk("stall_last_rd", at_or(rd_log, 3), 32'hC);
    chk("stall_head", obs_stall, 1'b0);
    i_exec_stall = 1'b0;
    step(); step();
    chk("stall_rd_0x10", at_or(rd_log, 4), 32'h10);

    // Jump while the read to 0x8 is in flight; its response arrives later.
    do_reset();
    lat_fixed = 2;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = obs_rdcmd && (obs_addr == 32'h8);
    end
    chk("jmp_saw_rd8", found, 1'b1);
    i_jump_valid = 1'b1; i_jump_addr = 32'h100;
    n0 = rd_log.size();
    step();
    i_jump_valid = 1'b0;
    for (int k = 0; k < 20 && rd_log.size() == n0; k++) step();
    chk("jmp_next_rd", at_or(rd_log, n0), 32'h100);
    wait_head();
    chk("jmp_first_pc", obs_pc, 32'h100);

    // Exception and jump together while stalled with a non-empty queue.
    do_reset();
    lat_fixed = 1;
    i_exec_stall = 1'b1;
    repeat (6) step();
    i_except_valid = 1'b1; i_except_haddr = 32'h180;
    i_jump_valid   = 1'b1; i_jump_addr    = 32'h200;
    n0 = rd_log.size();
    step();
    chk("exc_head_present", obs_stall, 1'b0);
    chk("exc_nop", obs_instr, NOP_W);
    i_except_valid = 1'b0; i_jump_valid = 1'b0;
    step();
    chk("exc_flushed", obs_stall, 1'b1);
    i_exec_stall = 1'b0;
    for (int k = 0; k < 20 && rd_log.size() == n0; k++) step();
    chk("exc_next_rd", at_or(rd_log, n0), 32'h180);

    // Bus error on the read to 0xC halts prefetch until a redirect.
    do_reset();
    bus_err_addr = 32'hC;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = !obs_stall && (obs_pc == 32'hC);
    end
    chk("berr_seen", found, 1'b1);
    chk("berr_flag", obs_be, 1'b1);
    chk("berr_instr", obs_instr, NOP_W);
    chk("berr_aflag", obs_ae, 1'b0);
    n0 = rd_log.size();
    repeat (12) step();
    chk("berr_halted", rd_log.size() - n0, 0);
    i_jump_valid = 1'b1; i_jump_addr = 32'h40;
    step();
    i_jump_valid = 1'b0;
    bus_err_addr = 32'hFFFF_FFFF;
    wait_head();
    chk("berr_redir_pc", obs_pc, 32'h40);
    chk("berr_cleared", obs_be, 1'b0);

    // Reset with entries queued and a read in flight.
    do_reset();
    lat_fixed = 3;
    i_exec_stall = 1'b1;
    repeat (14) step();
    chk("rst_mid_nonempty", obs_stall, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_exec_stall = 1'b0;
    n0 = rd_log.size();
    step();
    chk("rst_mid_stall", obs_stall, 1'b1);
    chk("rst_mid_rdcmd", obs_rdcmd, 1'b0);
    for (int k = 0; k < 20 && rd_log.size() == n0; k++) step();
    chk("rst_mid_rd_pc", at_or(rd_log, n0), 32'h0);

    // Randomised traffic against the model.
    do_reset();
    lat_fixed = 0;
    err_pct   = 2;
    for (int c = 0; c < 800; c++) begin
      i_exec_stall   = ($urandom_range(0, 99) < 25);
      i_mem_stall    = ($urandom_range(0, 99) < 10);
      i_nullify      = ($urandom_range(0, 99) < 10);
      i_busy         = ($urandom_range(0, 99) < 20);
      i_jump_valid   = ($urandom_range(0, 99) < 4);
      i_except_valid = ($urandom_range(0, 99) < 2);
      i_jump_addr    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      i_except_haddr = $urandom & 32'hFFFF_FFFC;
      step();
    end
    i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_nullify = 1'b0; i_busy = 1'b0;
    i_jump_valid = 1'b0; i_except_valid = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
